// File: rtl/barker_pkg.sv
// Shared constants and types for the Barker-11 serializer / correlator path.
// Exports BARKER_LEN, BARKER_SEQ and the serializer FSM state type.
package barker_pkg;

   localparam int BARKER_LEN = 11;
   localparam logic [BARKER_LEN-1:0] BARKER_SEQ = 11'b11100010010;

   typedef enum logic {
      SER_IDLE,
      SER_SHIFT
   } ser_state_t;

endpackage

// File: rtl/barker_mod_counter.sv
// Modulo-MOD up counter with synchronous clear.
// Ports: i_clk, i_rst_n (sync, active-low), inc, clr, cnt, wrap (cnt at MOD-1).
module barker_mod_counter
   import barker_pkg::*;
#(
   parameter int MOD = BARKER_LEN,
   localparam int W = $clog2(MOD)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] TOP = W'(MOD - 1);

   // Terminal-count flag, independent of inc so callers can use it as a level.
   assign wrap = (cnt == TOP);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/barker_bit_serializer.sv
// Word-to-bit AXI-Stream serializer feeding the Barker-11 correlator; m_tlast
// every FRAME_BITS bits and on the last bit of a packet. Zero-bubble reload.
// Ports: i_clk, i_rst_n (sync, active-low), s_tdata/s_tvalid/s_tlast/s_tready,
// m_tdata/m_tvalid/m_tlast/m_tready, o_busy.
// Build option: BARKER_SER_LSB_FIRST_EN selects LSB-first bit order.
module barker_bit_serializer
   import barker_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FRAME_BITS = BARKER_LEN
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic              m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic              o_busy
);

   localparam int BW = $clog2(DATA_W);
   localparam int FW = $clog2(FRAME_BITS);

   ser_state_t        state_q;
   ser_state_t        state_d;
   logic [DATA_W-1:0] word_q;
   logic              pkt_last_q;
   logic [BW-1:0]     bit_idx;
   logic [FW-1:0]     frame_cnt;
   logic              bit_end;
   logic              frame_end;
   logic              beat;
   logic              load;
   logic              frame_clr;

   assign beat = m_tvalid & m_tready;

   // A packet's final bit closes the frame early, whatever its position.
   assign frame_clr = beat & pkt_last_q & bit_end;

   barker_mod_counter #(.MOD(DATA_W)) u_bit_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .inc     (beat),
      .clr     (load),
      .cnt     (bit_idx),
      .wrap    (bit_end)
   );

   barker_mod_counter #(.MOD(FRAME_BITS)) u_frame_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .inc     (beat),
      .clr     (frame_clr),
      .cnt     (frame_cnt),
      .wrap    (frame_end)
   );

   // Frame position is consumed only through its terminal-count flag.
   logic unused_frame_cnt;
   assign unused_frame_cnt = ^frame_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= SER_IDLE;
         word_q     <= '0;
         pkt_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            word_q     <= s_tdata;
            pkt_last_q <= s_tlast;
         end
      end
   end

   // Outputs are gated by i_rst_n so nothing is offered or accepted
   // during the reset cycle itself.
   always_comb begin
      state_d  = state_q;
      s_tready = 1'b0;
      m_tvalid = 1'b0;
      o_busy   = 1'b0;
      load     = 1'b0;
      unique case (state_q)
         SER_IDLE: begin
            s_tready = i_rst_n;
            load     = s_tvalid & i_rst_n;
            if (load) state_d = SER_SHIFT;
         end
         SER_SHIFT: begin
            m_tvalid = i_rst_n;
            o_busy   = i_rst_n;
            // Last bit leaving: accept the next word in the same cycle.
            if (i_rst_n & m_tready & bit_end) begin
               s_tready = 1'b1;
               load     = s_tvalid;
               if (!s_tvalid) state_d = SER_IDLE;
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

`ifdef BARKER_SER_LSB_FIRST_EN
   assign m_tdata = m_tvalid & word_q[bit_idx];
`else
   localparam logic [BW-1:0] MSB_IDX = BW'(DATA_W - 1);
   assign m_tdata = m_tvalid & word_q[MSB_IDX - bit_idx];
`endif

   assign m_tlast = m_tvalid & (frame_end | (pkt_last_q & bit_end));

endmodule

// File: tb/tb_barker_bit_serializer.sv
// Directed self-checking bench for barker_bit_serializer (DATA_W=8,
// FRAME_BITS=11). Expected bit strings are written MSB-first per word.
module tb_barker_bit_serializer;

   logic       clk = 1'b0;
   logic       i_rst_n;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tlast;
   logic       s_tready;
   logic       m_tdata;
   logic       m_tvalid;
   logic       m_tlast;
   logic       m_tready;
   logic       o_busy;

   int errs = 0;
   int checks = 0;

   logic [7:0] wq[$];
   bit         lq[$];

   always #5 clk = ~clk;

   barker_bit_serializer #(
      .DATA_W     (8),
      .FRAME_BITS (11)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (i_rst_n),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .o_busy   (o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] w, input bit l);
      wq.push_back(w);
      lq.push_back(l);
   endtask

   // Feeds the queued words and checks n output beats against the
   // expected layout (len bits, MSB-first per word; lasts marks tlast).
   task automatic stream(input string tag, input logic [63:0] bits,
                         input logic [63:0] lasts, input int len,
                         input int n, input bit toggle);
      int k = 0;
      int cyc = 0;
      int hs_cyc = -1;
      int beat_cyc = -1;
      int bubbles = 0;
      int hs_n = 0;
      int nw = wq.size();
      int p;
      bit stall = 1'b0;
      logic pd = 1'b0;
      logic pl = 1'b0;
      while (k < n && cyc < 4 * n + 20) begin
         @(posedge clk); #1;
         s_tvalid = (wq.size() > 0);
         s_tdata  = s_tvalid ? wq[0] : 8'h00;
         s_tlast  = s_tvalid ? lq[0] : 1'b0;
         m_tready = toggle ? cyc[0] : 1'b1;
         @(negedge clk);
         if (stall) begin
            chk({tag, "_stall_valid"}, m_tvalid, 1'b1);
            chk({tag, "_stall_data"}, m_tdata, pd);
            chk({tag, "_stall_last"}, m_tlast, pl);
         end
         stall = m_tvalid && !m_tready;
         pd = m_tdata;
         pl = m_tlast;
         if (m_tvalid && m_tready) begin
            if (beat_cyc < 0) beat_cyc = cyc;
`ifdef BARKER_SER_LSB_FIRST_EN
            p = (k / 8) * 8 + 7 - (k % 8);
`else
            p = k;
`endif
            chk({tag, "_bit"}, m_tdata, bits[len-1-p]);
            chk({tag, "_last"}, m_tlast, lasts[len-1-k]);
            k++;
         end else if (beat_cyc >= 0) begin
            bubbles++;
         end
         if (s_tvalid && s_tready) begin
            if (hs_cyc < 0) hs_cyc = cyc;
            hs_n++;
            void'(wq.pop_front());
            void'(lq.pop_front());
         end
         cyc++;
      end
      chk({tag, "_beats"}, k, n);
      chk({tag, "_words"}, hs_n, nw);
      chk({tag, "_latency"}, beat_cyc - hs_cyc, 1);
      if (!toggle) chk({tag, "_bubbles"}, bubbles, 0);
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_valid"}, m_tvalid, 1'b0);
      chk({tag, "_idle_busy"}, o_busy, 1'b0);
      chk({tag, "_idle_ready"}, s_tready, 1'b1);
   endtask

   initial begin
      i_rst_n  = 1'b0;
      s_tdata  = 8'hFF;
      s_tvalid = 1'b1;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_tready", s_tready, 1'b0);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_m_tlast", m_tlast, 1'b0);
      chk("rst_m_tdata", m_tdata, 1'b0);
      chk("rst_o_busy", o_busy, 1'b0);
      @(posedge clk); #1;
      i_rst_n  = 1'b1;
      s_tvalid = 1'b0;
      @(negedge clk);
      chk("idle_s_tready", s_tready, 1'b1);
      chk("idle_m_tvalid", m_tvalid, 1'b0);

      // E2 then 40(last): frame tlast at bit 11, packet tlast at bit 16.
      push(8'hE2, 1'b0);
      push(8'h40, 1'b1);
      stream("t1", 64'hE240, 64'h0021, 16, 16, 1'b0);
      idle_check("t1");

      // Four back-to-back words, last flagged: tlast at bits 11, 22, 32.
      push(8'h12, 1'b0);
      push(8'h34, 1'b0);
      push(8'h56, 1'b0);
      push(8'h78, 1'b1);
      stream("t2", 64'h12345678, 64'h00200401, 32, 32, 1'b0);
      idle_check("t2");

      // New packet restarts the frame; stalls every other cycle.
      push(8'hFF, 1'b1);
      stream("t3", 64'hFF, 64'h01, 8, 8, 1'b1);
      idle_check("t3");

      // Reset after three bits of A5.
      push(8'hA5, 1'b0);
      stream("t4a", 64'hA5, 64'h00, 8, 3, 1'b0);
      @(posedge clk); #1;
      i_rst_n  = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'h11;
      m_tready = 1'b1;
      @(negedge clk);
      chk("t4_rst_valid", m_tvalid, 1'b0);
      chk("t4_rst_last", m_tlast, 1'b0);
      chk("t4_rst_ready", s_tready, 1'b0);
      @(posedge clk); #1;
      i_rst_n  = 1'b1;
      s_tvalid = 1'b0;
      @(negedge clk);
      chk("t4_post_valid", m_tvalid, 1'b0);
      chk("t4_post_busy", o_busy, 1'b0);
      push(8'h3C, 1'b0);
      push(8'h00, 1'b1);
      stream("t4b", 64'h3C00, 64'h0021, 16, 16, 1'b0);
      idle_check("t4");

      // 0x47: MSB-first 01000111, LSB-first 11100010.
      push(8'h47, 1'b1);
      stream("t6", 64'h47, 64'h01, 8, 8, 1'b0);
      idle_check("t6");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
